mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1: number of clock cycles each select value is held before f is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one scan of all four mux inputs.
REQ-005 sel  output  2  select driven to the downstream 4:1 mux select port.
REQ-006 f  input  1  mux output fed back for sampling.
REQ-007 data  output  4  assembled word; data[i] = f sampled while sel == i.
REQ-008 valid  output  1  data holds a complete scan result.
REQ-009 ready  input  1  consumer accepts data.
REQ-010 busy  output  1  high in SCAN and HOLD states.
REQ-011 parity  output  1  XOR of data bits; present only with SCAN_PARITY_EN.

Function
REQ-012 FSM states shall be IDLE, SCAN and HOLD; all outputs are registered.
- IDLE: sel = 0, valid = 0, busy = 0.
- SCAN: busy = 1.
- HOLD: valid = 1, busy = 1.
REQ-013 IDLE with start = 1 at edge E0 shall enter SCAN with index 0 and settle counter 0.
REQ-014 In SCAN, sel shall equal the index and be held for exactly SETTLE cycles per index.
REQ-015 f shall be sampled into bit [index] at edge E0 + SETTLE*(index+1); the index then increments; sel changes only on that same edge.
REQ-016 After bit 3 is sampled at E0 + 4*SETTLE:
- data shall load the full word, valid shall rise and the state shall go to HOLD.
- data shall not change during SCAN; it holds the previous result.
REQ-017 In HOLD, data and valid shall remain stable until ready = 1.
REQ-018 On a handshake (valid & ready), at the same edge:
- valid shall fall, and the state goes to IDLE;
- if start = 1 in that cycle, the state goes directly to SCAN with index 0 instead (back-to-back scan).
REQ-019 start shall be ignored in SCAN and in HOLD, except in the HOLD handshake cycle.
REQ-020 ready while valid = 0 shall have no effect.
REQ-021 Index and settle counters shall wrap only under FSM control; no index value above 3 shall ever appear on sel.
REQ-022 sel shall return to 0 when entering IDLE or HOLD.

Reset
REQ-023 rst_n = 0 shall immediately, independent of clk:
- force state IDLE;
- force sel = 0, data = 0, valid = 0, busy = 0 and parity = 0;
- clear both counters.
REQ-024 A reset during SCAN or HOLD shall abort the operation; no valid pulse shall follow reset release without a new start.
REQ-025 The first active edge after rst_n rises shall be able to accept start.

Configuration
REQ-026 With macro SCAN_PARITY_EN defined:
- the parity output exists;
- parity is registered, loaded together with data, and equals ^data.
REQ-027 Without SCAN_PARITY_EN, the parity port and its logic shall be absent; all other behaviour is identical.

Verification
REQ-028 The bench shall model the 4:1 mux combinationally from a[3:0] and sel, and shall cover these scenarios (SETTLE = 1 unless stated):
- Basic scan: a = 4'b1001, start pulse at E0, ready = 1 -> sel sequence 0,1,2,3 over E0..E0+3; valid high after E0+4; data = 4'b1001; parity = 0.
- Backpressure: a = 4'b0110, ready = 0 for 5 cycles after valid -> data = 4'b0110 stable and valid high for all 5 cycles; valid falls one edge after ready = 1.
- Back-to-back: start and ready both high in the handshake cycle with a changed to 4'b0111 -> direct HOLD->SCAN; second result data = 4'b0111, parity = 1.
- Settle timing: SETTLE = 3, a = 4'b1100 -> each sel value held 3 cycles; valid after E0+12; data = 4'b1100.
- Reset mid-scan: rst_n low after sel = 2 -> sel, data and valid are 0 immediately; no valid after release until a new start.
- Ignored start: start pulses during SCAN -> exactly one result and no restart of the sel sequence.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-select bundle between mux_scan_ctrl (master) and its environment (slave).
// The parity signal exists only when SCAN_PARITY_EN is defined.
interface mux_scan_ctrl_if;
    logic       start;
    logic [1:0] sel;
    logic       f;
    logic [3:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
`ifdef SCAN_PARITY_EN
    logic       parity;

    modport master (input start, f, ready, output sel, data, valid, busy, parity);
    modport slave  (output start, f, ready, input sel, data, valid, busy, parity);
`else
    modport master (input start, f, ready, output sel, data, valid, busy);
    modport slave  (output start, f, ready, input sel, data, valid, busy);
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans the four inputs of an external 4:1 mux through sel/f and assembles them into one word.
// Optional feature: define SCAN_PARITY_EN to add a registered parity output (^data).
module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input logic            clk,
    input logic            rst_n,
    mux_scan_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] acc, acc_nxt;
    logic [1:0] sel_r, sel_nxt;
    logic [3:0] data_r, data_nxt;
    logic       valid_r, valid_nxt;
    logic       busy_r, busy_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= 2'd0;
            cnt     <= 4'd0;
            acc     <= 3'd0;
            sel_r   <= 2'd0;
            data_r  <= 4'd0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            acc     <= acc_nxt;
            sel_r   <= sel_nxt;
            data_r  <= data_nxt;
            valid_r <= valid_nxt;
            busy_r  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        sel_nxt   = sel_r;
        data_nxt  = data_r;
        valid_nxt = valid_r;
        busy_nxt  = busy_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = SCAN;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = 4'd0;
                    sel_nxt   = 2'd0;
                    busy_nxt  = 1'b1;
                end
            end
            SCAN: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt = 4'd0;
                    // The last bit goes straight into data so the word updates atomically.
                    if (idx == 2'd3) begin
                        data_nxt  = {bus.f, acc};
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                        idx_nxt   = 2'd0;
                        sel_nxt   = 2'd0;
                    end else begin
                        acc_nxt[idx] = bus.f;
                        idx_nxt      = idx + 2'd1;
                        sel_nxt      = idx + 2'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HOLD: begin
                if (bus.ready) begin
                    valid_nxt = 1'b0;
                    if (bus.start) begin
                        state_nxt = SCAN;
                        idx_nxt   = 2'd0;
                        cnt_nxt   = 4'd0;
                        sel_nxt   = 2'd0;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = 2'd0;
                valid_nxt = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.sel   = sel_r;
    assign bus.data  = data_r;
    assign bus.valid = valid_r;
    assign bus.busy  = busy_r;

`ifdef SCAN_PARITY_EN
    logic parity_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= ^data_nxt;
        end
    end

    assign bus.parity = parity_r;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed plus randomized bench for mux_scan_ctrl with SETTLE = 1 and SETTLE = 3 instances.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_d;
    logic       ready_d;
    logic [3:0] a_d;
    logic       cur;

    int vectors;
    int miscompares;
    logic [3:0] prev [2];

    mux_scan_ctrl_if if1 ();
    mux_scan_ctrl_if if3 ();

    mux_scan_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mux_scan_ctrl #(.SETTLE(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    // Behavioural 4:1 mux on each instance
    assign if1.f     = a_d[if1.sel];
    assign if3.f     = a_d[if3.sel];
    assign if1.start = start_d & ~cur;
    assign if3.start = start_d & cur;
    assign if1.ready = ready_d & ~cur;
    assign if3.ready = ready_d & cur;

    logic [1:0] o_sel;
    logic [3:0] o_data;
    logic       o_valid;
    logic       o_busy;
    assign o_sel   = cur ? if3.sel   : if1.sel;
    assign o_data  = cur ? if3.data  : if1.data;
    assign o_valid = cur ? if3.valid : if1.valid;
    assign o_busy  = cur ? if3.busy  : if1.busy;
`ifdef SCAN_PARITY_EN
    logic o_par;
    assign o_par = cur ? if3.parity : if1.parity;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_sel"}, o_sel, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_busy"}, o_busy, 0);
`ifdef SCAN_PARITY_EN
        chk({tag, "_parity"}, o_par, 0);
`endif
    endtask

    task automatic start_scan(input logic [3:0] val);
        a_d     = val;
        start_d = 1'b1;
        step();
        start_d = 1'b0;
    endtask

    // Entered just after the start edge E0; runs scan, hold and handshake.
    task automatic finish_scan(input logic [3:0] val, input int hold, input bit b2b,
                               input logic [3:0] nxt, input bit poke);
        int s;
        s = cur ? 3 : 1;
        chk("scan_sel_first", o_sel, 0);
        chk("scan_busy", o_busy, 1);
        chk("scan_valid", o_valid, 0);
        for (int t = 1; t < 4 * s; t++) begin
            start_d = poke && (t % 2 == 1);
            step();
            chk("scan_sel", o_sel, t / s);
            chk("scan_data_hold", o_data, prev[cur]);
            chk("scan_valid_low", o_valid, 0);
            chk("scan_busy_high", o_busy, 1);
        end
        start_d = 1'b0;
        step();
        chk("result_valid", o_valid, 1);
        chk("result_data", o_data, val);
        chk("result_sel", o_sel, 0);
        chk("result_busy", o_busy, 1);
`ifdef SCAN_PARITY_EN
        chk("result_parity", o_par, ^val);
`endif
        for (int h = 0; h < hold; h++) begin
            ready_d = 1'b0;
            start_d = 1'($urandom_range(0, 1));
            step();
            chk("hold_valid", o_valid, 1);
            chk("hold_data", o_data, val);
            chk("hold_busy", o_busy, 1);
            chk("hold_sel", o_sel, 0);
        end
        ready_d = 1'b1;
        start_d = b2b;
        if (b2b) a_d = nxt;
        step();
        ready_d = 1'b0;
        start_d = 1'b0;
        chk("hs_valid", o_valid, 0);
        chk("hs_data", o_data, val);
        chk("hs_busy", o_busy, 32'(b2b));
        chk("hs_sel", o_sel, 0);
        prev[cur] = val;
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] n;
        vectors     = 0;
        miscompares = 0;
        prev[0]     = 4'd0;
        prev[1]     = 4'd0;
        rst_n   = 1'b0;
        start_d = 1'b0;
        ready_d = 1'b0;
        a_d     = 4'd0;
        cur     = 1'b0;
        #2;
        chk_cleared("reset1");
        cur = 1'b1;
        #1;
        chk_cleared("reset3");
        cur = 1'b0;
        #8;
        rst_n = 1'b1;

        // Basic scan, immediate accept
        start_scan(4'b1001);
        finish_scan(4'b1001, 0, 1'b0, 4'd0, 1'b0);

        // ready without valid does nothing
        ready_d = 1'b1;
        step();
        step();
        chk("idle_ready_valid", o_valid, 0);
        chk("idle_ready_busy", o_busy, 0);
        ready_d = 1'b0;

        // Backpressure then back-to-back
        start_scan(4'b0110);
        finish_scan(4'b0110, 5, 1'b1, 4'b0111, 1'b0);
        finish_scan(4'b0111, 0, 1'b0, 4'd0, 1'b0);

        // Settle timing on the SETTLE = 3 instance
        cur = 1'b1;
        #1;
        start_scan(4'b1100);
        finish_scan(4'b1100, 1, 1'b0, 4'd0, 1'b0);

        // Start pulses during SCAN are ignored
        cur = 1'b0;
        v = 4'($urandom);
        start_scan(v);
        finish_scan(v, 0, 1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_restart_busy", o_busy, 0);
            chk("no_restart_valid", o_valid, 0);
        end

        // Reset mid-scan
        start_scan(4'b1111);
        step();
        step();
        chk("pre_reset_sel", o_sel, 2);
        rst_n = 1'b0;
        #1;
        chk_cleared("async_reset1");
        cur = 1'b1;
        #1;
        chk_cleared("async_reset3");
        cur = 1'b0;
        prev[0] = 4'd0;
        prev[1] = 4'd0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post_reset_valid", o_valid, 0);
            chk("post_reset_busy", o_busy, 0);
        end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        v = 4'($urandom);
        start_scan(v);
        finish_scan(v, 0, 1'b0, 4'd0, 1'b0);

        // Randomized scans on both instances
        for (int r = 0; r < 10; r++) begin
            cur = 1'($urandom_range(0, 1));
            #1;
            v = 4'($urandom);
            n = 4'($urandom);
            start_scan(v);
            if ($urandom_range(0, 1) == 1) begin
                finish_scan(v, int'($urandom_range(0, 4)), 1'b1, n, 1'($urandom_range(0, 1)));
                finish_scan(n, int'($urandom_range(0, 4)), 1'b0, 4'd0, 1'($urandom_range(0, 1)));
            end else begin
                finish_scan(v, int'($urandom_range(0, 4)), 1'b0, 4'd0, 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
